// File: rtl/fpu_exec_sequencer.sv
// rtl/fpu_exec_sequencer.sv - Execute-stage FP operation sequencer
// Starts the FPU datapath, times fixed-latency ops, and waits on div/sqrt with a watchdog.
module fpu_exec_sequencer #(
    parameter int LAT_ADD = 2,
    parameter int LAT_MUL = 3,
    parameter int CW      = 4,
    parameter int TIMEOUT = 63,
    parameter int TW      = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       FPUReqE,
    input  logic [1:0] FPUOpE,
    input  logic       KillE,
    input  logic       UnitDone,
    output logic       UnitStart,
    output logic [1:0] UnitOp,
    output logic       UnitAbort,
    output logic       ResultEn,
    output logic       FPUOkE,
    output logic       FPUErr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seqState_t;

    seqState_t         state;
    seqState_t         nextState;
    logic [CW-1:0]     latCnt;
    logic [TW-1:0]     wdogCnt;
    logic              setErr;
    logic              isVar;

    // Op class bit 1 selects the handshake-completed div/sqrt datapath.
    assign isVar = UnitOp[1];

    always_comb begin
        nextState = state;
        UnitStart = 1'b0;
        UnitAbort = 1'b0;
        ResultEn  = 1'b0;
        FPUOkE    = 1'b1;
        setErr    = 1'b0;
        case (state)
            IDLE: begin
                FPUOkE = !FPUReqE;
                if (FPUReqE && !KillE) begin
                    UnitStart = 1'b1;
                    nextState = RUN;
                end
            end
            RUN: begin
                if (KillE) begin
                    UnitAbort = 1'b1;
                    nextState = IDLE;
                end else begin
                    FPUOkE = 1'b0;
                    if (isVar) begin
                        if (UnitDone) begin
                            nextState = DONE;
                        end else if (wdogCnt == TW'(TIMEOUT - 1)) begin
                            setErr    = 1'b1;
                            nextState = DONE;
                        end
                    end else if (latCnt == '0) begin
                        nextState = DONE;
                    end
                end
            end
            DONE: begin
                // The finished op's request is still high here; returning to IDLE
                // lets the pipeline present the next instruction before a new start.
                ResultEn  = !KillE;
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
        if (reset) begin
            UnitStart = 1'b0;
            UnitAbort = 1'b0;
            ResultEn  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            latCnt  <= '0;
            wdogCnt <= '0;
            UnitOp  <= 2'b00;
            FPUErr  <= 1'b0;
        end else begin
            state <= nextState;
            if (UnitStart) begin
                UnitOp  <= FPUOpE;
                latCnt  <= (FPUOpE == 2'b01) ? CW'(LAT_MUL - 1) : CW'(LAT_ADD - 1);
                wdogCnt <= '0;
            end else if (state == RUN) begin
                if (!isVar && latCnt != '0) begin
                    latCnt <= latCnt - CW'(1);
                end
                if (isVar) begin
                    wdogCnt <= wdogCnt + TW'(1);
                end
            end
            if (setErr) begin
                FPUErr <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fpu_exec_sequencer.sv
// tb/tb_fpu_exec_sequencer.sv - self-checking bench for fpu_exec_sequencer
// Directed scenarios with literal expectations plus randomized traffic against a cycle-count model.
module tb_fpu_exec_sequencer;

    localparam int LAT_ADD = 2;
    localparam int LAT_MUL = 3;
    localparam int CW      = 4;
    localparam int TIMEOUT = 63;
    localparam int TW      = 6;

    logic       clk = 1'b0;
    logic       reset;
    logic       FPUReqE;
    logic [1:0] FPUOpE;
    logic       KillE;
    logic       UnitDone;
    logic       UnitStart;
    logic [1:0] UnitOp;
    logic       UnitAbort;
    logic       ResultEn;
    logic       FPUOkE;
    logic       FPUErr;

    int vectors = 0;
    int miscompares = 0;

    fpu_exec_sequencer #(
        .LAT_ADD(LAT_ADD),
        .LAT_MUL(LAT_MUL),
        .CW(CW),
        .TIMEOUT(TIMEOUT),
        .TW(TW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .FPUReqE(FPUReqE),
        .FPUOpE(FPUOpE),
        .KillE(KillE),
        .UnitDone(UnitDone),
        .UnitStart(UnitStart),
        .UnitOp(UnitOp),
        .UnitAbort(UnitAbort),
        .ResultEn(ResultEn),
        .FPUOkE(FPUOkE),
        .FPUErr(FPUErr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model: phase 0 = waiting for a request, 1 = busy for mK cycles so far, 2 = result cycle.
    int         mPh = 0;
    int         mK = 0;
    logic [1:0] mOp = 2'b00;
    logic       mErr = 1'b0;
    logic       mValid = 1'b0;

    function automatic int latOf(input logic [1:0] op);
        return (op == 2'b01) ? LAT_MUL : LAT_ADD;
    endfunction

    always @(posedge clk) begin
        mValid <= mValid | reset;
        if (reset) begin
            mPh  <= 0;
            mK   <= 0;
            mOp  <= 2'b00;
            mErr <= 1'b0;
        end else begin
            case (mPh)
                0: if (FPUReqE && !KillE) begin
                    mPh <= 1;
                    mK  <= 1;
                    mOp <= FPUOpE;
                end
                1: if (KillE) begin
                    mPh <= 0;
                end else begin
                    if (mOp < 2'd2) begin
                        if (mK == latOf(mOp)) mPh <= 2;
                    end else if (UnitDone) begin
                        mPh <= 2;
                    end else if (mK == TIMEOUT) begin
                        mPh  <= 2;
                        mErr <= 1'b1;
                    end
                    mK <= mK + 1;
                end
                default: mPh <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (mValid) begin
            int eStart;
            int eAbort;
            int eRe;
            int eOk;
            eStart = 0;
            eAbort = 0;
            eRe    = 0;
            eOk    = 1;
            case (mPh)
                0: begin
                    eOk    = int'(!FPUReqE);
                    eStart = int'(FPUReqE && !KillE);
                end
                1: if (KillE) eAbort = 1; else eOk = 0;
                default: eRe = int'(!KillE);
            endcase
            if (reset) begin
                eStart = 0;
                eAbort = 0;
                eRe    = 0;
            end
            chk("model_start", int'(UnitStart), eStart);
            chk("model_abort", int'(UnitAbort), eAbort);
            chk("model_result_en", int'(ResultEn), eRe);
            chk("model_unit_op", int'(UnitOp), int'(mOp));
            chk("model_err", int'(FPUErr), int'(mErr));
            if (!reset) chk("model_ok", int'(FPUOkE), eOk);
        end
    end

    initial begin
        reset    = 1'b1;
        FPUReqE  = 1'b0;
        FPUOpE   = 2'b00;
        KillE    = 1'b0;
        UnitDone = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_ok", int'(FPUOkE), 1);
        chk("rst_op", int'(UnitOp), 0);
        chk("rst_err", int'(FPUErr), 0);
        chk("rst_start", int'(UnitStart), 0);
        step();

        // Add: stall 3 cycles, result in cycle 3.
        for (int c = 0; c <= 4; c++) begin
            FPUReqE = (c < 4);
            FPUOpE  = 2'b00;
            @(negedge clk);
            chk("add_ok", int'(FPUOkE), int'(c >= 3));
            chk("add_re", int'(ResultEn), int'(c == 3));
            chk("add_start", int'(UnitStart), int'(c == 0));
            step();
        end

        // Mul then add back to back.
        for (int c = 0; c <= 9; c++) begin
            FPUReqE = (c < 9);
            FPUOpE  = (c < 5) ? 2'b01 : 2'b00;
            @(negedge clk);
            chk("muladd_start", int'(UnitStart), int'(c == 0 || c == 5));
            chk("muladd_re", int'(ResultEn), int'(c == 4 || c == 8));
            chk("muladd_ok", int'(FPUOkE), int'(c == 4 || c >= 8));
            if (c >= 1) chk("muladd_op", int'(UnitOp), (c <= 5) ? 1 : 0);
            step();
        end

        // Div completing in the 7th busy cycle.
        for (int c = 0; c <= 9; c++) begin
            FPUReqE  = (c < 9);
            FPUOpE   = 2'b10;
            UnitDone = (c == 7);
            @(negedge clk);
            chk("div_ok", int'(FPUOkE), int'(c >= 8));
            chk("div_re", int'(ResultEn), int'(c == 8));
            chk("div_err", int'(FPUErr), 0);
            step();
        end
        UnitDone = 1'b0;

        // Div with no completion: watchdog fires after 63 busy cycles.
        for (int c = 0; c <= 66; c++) begin
            FPUReqE = (c < 65);
            FPUOpE  = 2'b10;
            @(negedge clk);
            chk("wdog_ok", int'(FPUOkE), int'(c >= 64));
            chk("wdog_re", int'(ResultEn), int'(c == 64));
            chk("wdog_err", int'(FPUErr), int'(c >= 64));
            step();
        end

        // Sqrt killed in its 2nd busy cycle while the unit also reports done.
        for (int c = 0; c <= 3; c++) begin
            FPUReqE  = (c < 3);
            FPUOpE   = 2'b11;
            KillE    = (c == 2);
            UnitDone = (c == 2);
            @(negedge clk);
            chk("kill_start", int'(UnitStart), int'(c == 0));
            chk("kill_abort", int'(UnitAbort), int'(c == 2));
            chk("kill_re", int'(ResultEn), 0);
            chk("kill_ok", int'(FPUOkE), int'(c >= 2));
            chk("kill_err_sticky", int'(FPUErr), 1);
            step();
        end
        KillE    = 1'b0;
        UnitDone = 1'b0;

        // Reset in the middle of a mul, then an add waiting on the first free cycle.
        for (int c = 0; c <= 7; c++) begin
            reset   = (c == 2);
            FPUReqE = (c <= 1) || (c >= 3 && c <= 6);
            FPUOpE  = (c < 3) ? 2'b01 : 2'b00;
            @(negedge clk);
            if (c == 2) begin
                chk("rstmid_start", int'(UnitStart), 0);
                chk("rstmid_abort", int'(UnitAbort), 0);
                chk("rstmid_re", int'(ResultEn), 0);
            end
            if (c == 3) begin
                chk("rstmid_op", int'(UnitOp), 0);
                chk("rstmid_err", int'(FPUErr), 0);
                chk("rstmid_restart", int'(UnitStart), 1);
                chk("rstmid_ok", int'(FPUOkE), 0);
            end
            if (c == 6) chk("rstmid_add_re", int'(ResultEn), 1);
            if (c == 7) chk("rstmid_idle_ok", int'(FPUOkE), 1);
            step();
        end

        // Random traffic; the early window starves UnitDone so the watchdog gets exercised.
        for (int i = 0; i < 3000; i++) begin
            reset    = ($urandom_range(0, 149) == 0);
            FPUReqE  = ($urandom_range(0, 3) != 0);
            FPUOpE   = 2'($urandom_range(0, 3));
            KillE    = ($urandom_range(0, 19) == 0);
            UnitDone = (i % 1000 < 300) ? 1'b0 : ($urandom_range(0, 5) == 0);
            @(negedge clk);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
